seq_divider: RTL and testbench
==============================

# seq_divider

Iterative unsigned restoring divider that undoes the team's 3×3 combinational multiplier. It takes a 6-bit product and a 3-bit factor and returns the 6-bit quotient and 3-bit remainder, retiring one quotient bit per clock. It sits beside the multiplier as its inverse operator and uses a start/busy/done handshake toward the controlling logic.

## Interface
- `WN`, 6: dividend and quotient width
- `WD`, 3: divisor and remainder width
- `clk` input 1: rising-edge clock
- `rst` input 1: asynchronous, active-high reset
- `start` input 1: request a divide; sampled only when not busy
- `dividend` input WN: unsigned numerator, captured on accepted start
- `divisor` input WD: unsigned denominator, captured on accepted start
- `busy` output 1: division in progress
- `done` output 1: one-cycle pulse; results valid from this cycle on
- `quotient` output WN: unsigned quotient, held until next result
- `remainder` output WD: unsigned remainder, held until next result
- `dbz` output 1: last result was divide-by-zero, held with results

## Operation
- States:
  - IDLE: reset state; also the resting state after completion.
  - RUN: iterates.
  - FIN: loads outputs and pulses `done`, then returns to IDLE.
- Accept rule: `start`=1 in IDLE captures the operands and clears the step counter.
  - Nonzero divisor goes to RUN.
  - Zero divisor goes directly to FIN with the dbz path selected.
- `start` in RUN or FIN is ignored; captured operands are not disturbed.
- Internal partial remainder is WD+1 bits to hold the shifted value before the compare.
- RUN step i, for i = 0..WN-1, working MSB first:
  - Shift the next dividend bit into the partial remainder.
  - If partial ≥ divisor: subtract, and the quotient bit is 1.
  - Otherwise the quotient bit is 0.
- The counter wraps WN-1 → exit to FIN; no other wrap.
- FIN, normal case: `quotient`/`remainder` load the computed values and `dbz`=0.
- FIN, dbz case: `quotient` = all ones, `remainder` = 0, `dbz`=1.
- Invariant for nonzero divisor: quotient·divisor + remainder = dividend, remainder < divisor.
- Reset, at any time including mid-RUN:
  - Forces IDLE and discards the operation.
  - Clears all outputs: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `dbz`=0.

## Timing
- Start accepted at edge k.
- `busy` is registered:
  - Normal case: high in cycles after edges k … k+WN (WN+1 cycles).
  - dbz case: high in cycles after edges k … k (1 cycle).
- Normal case: RUN occupies edges k+1 … k+WN. Outputs update and `done`=1 in the cycle after edge k+WN+1, with `busy`=0 in the same cycle. Latency is WN+1 = 7 edges from accept to valid.
- dbz case: outputs update and `done`=1 after edge k+1 (latency 1).
- `done` is high exactly one cycle. A new `start` may be accepted in the same cycle `done` is high, since the block is in IDLE.
- Outputs change only on a FIN edge or reset; they are stable while `busy`.

## Structure
- Package `div_pkg`:
  - `WN`/`WD` default constants.
  - State enum `div_state_t` {IDLE, RUN, FIN}.
  - Counter width constant `$clog2(WN)`.
- Sub-module `div_step` (combinational):
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once and reused each RUN cycle.
- Top holds the FSM, counter, operand/quotient shift registers and output registers.

## Test plan
- Reset mid-RUN: start 63/5, assert `rst` at edge k+3 → all outputs 0 and IDLE immediately. A following start of 10/2 gives Q=5, R=0 normally.
- Exact inverses of multiplier vectors:
  - 3/3 → Q=1, R=0.
  - 10/2 → Q=5, R=0.
  - 0/6 → Q=0, R=0.
  - 21/7 → Q=3, R=0.
  - Each: `done` exactly 7 edges after accept, `busy` 7 cycles.
- Remainders and width extremes:
  - 63/5 → Q=12, R=3.
  - 63/1 → Q=63, R=0.
  - 5/7 → Q=0, R=5.
  - 62/7 → Q=8, R=6.
- Divide by zero: 45/0 → after 1 edge Q=63, R=0, `dbz`=1, `done` pulse. The next 9/3 clears `dbz` and gives Q=3.
- Start while busy: start 63/5, then pulse start with 10/2 during RUN → ignored; result Q=12, R=3. Start issued in the `done` cycle is accepted.
- Random 500 pairs checked against quotient·divisor+remainder=dividend, remainder<divisor, and outputs stable while `busy`.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int unsigned WN_DEFAULT = 6;
  localparam int unsigned WD_DEFAULT = 3;
  localparam int unsigned CNT_W      = $clog2(WN_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WN = WN_DEFAULT,
  parameter int unsigned WD = WD_DEFAULT
) ();

  logic          start;
  logic [WN-1:0] dividend;
  logic [WD-1:0] divisor;
  logic          busy;
  logic          done;
  logic [WN-1:0] quotient;
  logic [WD-1:0] remainder;
  logic          dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );

endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WD = WD_DEFAULT
) (
  input  logic [WD-1:0] part_i,
  input  logic          bit_i,
  input  logic [WD-1:0] divisor_i,
  output logic [WD-1:0] part_o,
  output logic          q_o
);

  logic [WD:0]   shifted;
  logic [WD-1:0] diff;

  // A successful subtract always leaves a value below the divisor, so the
  // low WD bits of the difference are exact.
  always_comb begin
    shifted = {part_i, bit_i};
    diff    = shifted[WD-1:0] - divisor_i;
    q_o     = (shifted >= {1'b0, divisor_i});
    part_o  = q_o ? diff : shifted[WD-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WN = WN_DEFAULT,
  parameter int unsigned WD = WD_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WN);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WN-1:0] dvd_q, dvd_d;
  logic [WN-1:0] quo_q, quo_d;
  logic [WD-1:0] dvs_q, dvs_d;
  logic [WD-1:0] part_q, part_d;
  logic [WN-1:0] q_out_q, q_out_d;
  logic [WD-1:0] r_out_q, r_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [WD-1:0] step_part;
  logic          step_bit;

  div_step #(.WD(WD)) u_step (
    .part_i    (part_q),
    .bit_i     (dvd_q[WN-1]),
    .divisor_i (dvs_q),
    .part_o    (step_part),
    .q_o       (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          part_d  = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = (bus.divisor == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        part_d = step_part;
        dvd_d  = {dvd_q[WN-2:0], 1'b0};
        quo_d  = {quo_q[WN-2:0], step_bit};
        if (cnt_q == CW'(WN - 1)) begin
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dvs_q == '0) begin
          q_out_d = '1;
          r_out_d = '0;
          dbz_d   = 1'b1;
        end else begin
          q_out_d = quo_q;
          r_out_d = part_q;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy is registered from the next state so it rises on the accept edge.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = q_out_q;
  assign bus.remainder = r_out_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider against hand-computed results.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WN(6), .WD(3)) bus ();

  seq_divider #(.WN(6), .WD(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issues one divide and returns edges-to-done, busy cycles and output stability.
  task automatic do_div(input logic [5:0] a, input logic [2:0] b,
                        output int lat, output int bcnt, output bit stable);
    logic [5:0] q0;
    logic [2:0] r0;
    logic       z0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    q0 = bus.quotient;
    r0 = bus.remainder;
    z0 = bus.dbz;
    lat    = -1;
    bcnt   = 0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (bus.busy === 1'b1) begin
        bcnt++;
        if (bus.quotient !== q0 || bus.remainder !== r0 || bus.dbz !== z0) stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact();
    logic [5:0] a  [4] = '{6'd3, 6'd10, 6'd0, 6'd21};
    logic [2:0] b  [4] = '{3'd3, 3'd2, 3'd6, 3'd7};
    logic [5:0] eq [4] = '{6'd1, 6'd5, 6'd0, 6'd3};
    int lat, bc;
    bit st;
    foreach (a[i]) begin
      do_div(a[i], b[i], lat, bc, st);
      total++;
      if (bus.quotient !== eq[i] || bus.remainder !== 3'd0 || bus.dbz !== 1'b0) begin
        bad++;
        $display("FAIL exact %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=0 z=0",
                 a[i], b[i], bus.quotient, bus.remainder, bus.dbz, eq[i]);
      end
      total++;
      if (lat != 7 || bc != 7 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL exact_timing %0d/%0d: got lat=%0d busy_cycles=%0d busy_at_done=%b want 7 7 0",
                 a[i], b[i], lat, bc, bus.busy);
      end
      total++;
      if (!st) begin
        bad++;
        $display("FAIL exact_stable %0d/%0d: got outputs changing while busy want stable", a[i], b[i]);
      end
    end
  endtask

  task automatic test_remainders();
    logic [5:0] a  [4] = '{6'd63, 6'd63, 6'd5, 6'd62};
    logic [2:0] b  [4] = '{3'd5, 3'd1, 3'd7, 3'd7};
    logic [5:0] eq [4] = '{6'd12, 6'd63, 6'd0, 6'd8};
    logic [2:0] er [4] = '{3'd3, 3'd0, 3'd5, 3'd6};
    int lat, bc;
    bit st;
    foreach (a[i]) begin
      do_div(a[i], b[i], lat, bc, st);
      total++;
      if (bus.quotient !== eq[i] || bus.remainder !== er[i] || lat != 7) begin
        bad++;
        $display("FAIL rem %0d/%0d: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=7",
                 a[i], b[i], bus.quotient, bus.remainder, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc;
    bit st;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 6'd63;
    bus.divisor  = 3'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz} !== 12'd0) begin
      bad++;
      $display("FAIL reset_mid_run: got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    @(negedge clk);
    rst = 1'b0;
    do_div(6'd10, 3'd2, lat, bc, st);
    total++;
    if (bus.quotient !== 6'd5 || bus.remainder !== 3'd0 || lat != 7) begin
      bad++;
      $display("FAIL after_reset 10/2: got q=%0d r=%0d lat=%0d want q=5 r=0 lat=7",
               bus.quotient, bus.remainder, lat);
    end
  endtask

  task automatic test_dbz();
    int lat, bc;
    bit st;
    do_div(6'd45, 3'd0, lat, bc, st);
    total++;
    if (bus.quotient !== 6'd63 || bus.remainder !== 3'd0 || bus.dbz !== 1'b1) begin
      bad++;
      $display("FAIL dbz 45/0: got q=%0d r=%0d z=%b want q=63 r=0 z=1",
               bus.quotient, bus.remainder, bus.dbz);
    end
    total++;
    if (lat != 1 || bc != 1) begin
      bad++;
      $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d want 1 1", lat, bc);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.dbz !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: got done=%b dbz=%b one cycle later want done=0 dbz=1", bus.done, bus.dbz);
    end
    do_div(6'd9, 3'd3, lat, bc, st);
    total++;
    if (bus.quotient !== 6'd3 || bus.remainder !== 3'd0 || bus.dbz !== 1'b0 || lat != 7) begin
      bad++;
      $display("FAIL dbz_clear 9/3: got q=%0d r=%0d z=%b lat=%0d want q=3 r=0 z=0 lat=7",
               bus.quotient, bus.remainder, bus.dbz, lat);
    end
  endtask

  task automatic test_start_busy();
    int lat, bc;
    bit st, seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 6'd63;
    bus.divisor  = 3'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 6'd10;
    bus.divisor  = 3'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat  = 3;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    total++;
    if (bus.quotient !== 6'd12 || bus.remainder !== 3'd3 || lat != 7 || !seen) begin
      bad++;
      $display("FAIL start_busy: got q=%0d r=%0d lat=%0d done=%b want q=12 r=3 lat=7 done=1",
               bus.quotient, bus.remainder, lat, seen);
    end
    // do_div drives start while done is still high from the previous result.
    do_div(6'd10, 3'd2, lat, bc, st);
    total++;
    if (bus.quotient !== 6'd5 || bus.remainder !== 3'd0 || lat != 7) begin
      bad++;
      $display("FAIL back_to_back 10/2: got q=%0d r=%0d lat=%0d want q=5 r=0 lat=7",
               bus.quotient, bus.remainder, lat);
    end
  endtask

  task automatic test_random();
    logic [5:0]  a;
    logic [2:0]  b;
    logic [11:0] recon;
    int lat, bc;
    bit st;
    for (int n = 0; n < 500; n++) begin
      a = 6'($urandom_range(0, 63));
      b = 3'($urandom_range(1, 7));
      do_div(a, b, lat, bc, st);
      recon = bus.quotient * b + bus.remainder;
      total++;
      if (recon !== {6'd0, a} || bus.remainder >= b || bus.dbz !== 1'b0) begin
        bad++;
        $display("FAIL rand %0d/%0d: got q=%0d r=%0d z=%b want q*d+r=%0d r<%0d z=0",
                 a, b, bus.quotient, bus.remainder, bus.dbz, a, b);
      end
      total++;
      if (lat != 7 || bc != 7 || !st) begin
        bad++;
        $display("FAIL rand_timing %0d/%0d: got lat=%0d busy_cycles=%0d stable=%b want 7 7 1",
                 a, b, lat, bc, st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_remainders();
    test_reset_mid_run();
    test_dbz();
    test_start_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
